// File: rtl/screen_pkg.sv
// Shared types and constants for the full-screen display flow:
// sequencer states, screen select codes and the fade ceiling.
package screen_pkg;

    typedef enum logic [2:0] {
        START,
        FADE_OUT,
        FADE_IN,
        GAME,
        GAMEOVER
    } screen_state_t;

    localparam logic [1:0] SCREEN_START = 2'd0;
    localparam logic [1:0] SCREEN_GAME  = 2'd1;
    localparam logic [1:0] SCREEN_OVER  = 2'd2;

    localparam logic [3:0] FADE_MAX = 4'd15;

    // ROM/palette select code that shows a given resting state.
    function automatic logic [1:0] screen_of(input screen_state_t s);
        case (s)
            GAME:     return SCREEN_GAME;
            GAMEOVER: return SCREEN_OVER;
            default:  return SCREEN_START;
        endcase
    endfunction

endpackage

// File: rtl/fade_scale.sv
// Per-channel brightness scale: c_out = (c*fade + 7)/15, rounded to nearest.
// fade = 15 returns c unchanged, fade = 0 returns 0.
module fade_scale (
    input  logic [3:0] c,
    input  logic [3:0] fade,
    output logic [3:0] c_out
);

    logic [7:0] prod;

    // Product plus half-divisor fits in 8 bits (225 + 7); quotient never exceeds 15.
    always_comb begin
        prod  = ({4'b0, c} * {4'b0, fade}) + 8'd7;
        c_out = 4'(prod / 8'd15);
    end

endmodule

// File: rtl/screen_sequencer.sv
// Display-flow controller for the start / game / game-over screens.
// Sequences screens on frame boundaries, fades the palette colour between
// screens, generates the stretched image ROM address and registers the VGA
// colour. Build option SCREEN_INSTANT_SWITCH_EN removes the fades: an accepted
// event switches screen and state on the next frame tick at full brightness.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int H_RES            = 640,
    parameter int V_RES            = 480,
    parameter int IMG_W            = 320,
    parameter int IMG_H            = 240,
    parameter int FADE_STEP_FRAMES = 4,
    parameter int HOLD_FRAMES      = 120
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        start_key,
    input  logic        game_over,
    input  logic [3:0]  pal_red,
    input  logic [3:0]  pal_green,
    input  logic [3:0]  pal_blue,
    output logic [16:0] rom_address,
    output logic [1:0]  screen_sel,
    output logic        in_game,
    output logic        fading,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_FRAMES - 1);

    screen_state_t   state;
    screen_state_t   target;
    logic [3:0]      fade;
    logic [HC_W-1:0] hold_cnt;
    logic            at_origin;
    logic            at_origin_q;
    logic            frame_tick;
    logic            start_q;
    logic            over_q;
    logic            start_rise;
    logic            over_rise;
    logic [3:0]      red_s;
    logic [3:0]      green_s;
    logic [3:0]      blue_s;
    logic [18:0]     x_prod;
    logic [18:0]     y_prod;
    logic [18:0]     x_img;
    logic [18:0]     y_img;

    // Stretch the screen position onto the smaller stored image.
    assign x_prod      = 19'(DrawX) * 19'(IMG_W);
    assign x_img       = x_prod / 19'(H_RES);
    assign y_prod      = 19'(DrawY) * 19'(IMG_H);
    assign y_img       = y_prod / 19'(V_RES);
    assign rom_address = 17'(x_img + y_img * 19'(IMG_W));

    assign at_origin  = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign start_rise = start_key & ~start_q;
    assign over_rise  = game_over & ~over_q;

    assign in_game = (state == GAME);
    assign fading  = (state == FADE_OUT) || (state == FADE_IN);

    // One tick per frame on arrival at the origin; edge history for the events.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            at_origin_q <= 1'b0;
            frame_tick  <= 1'b0;
            start_q     <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            frame_tick  <= at_origin & ~at_origin_q;
            start_q     <= start_key;
            over_q      <= game_over;
        end
    end

`ifdef SCREEN_INSTANT_SWITCH_EN
    logic pending;

    assign fade = FADE_MAX;

    // Screen FSM without fades: accepted events wait for the next frame tick.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= START;
            target     <= START;
            screen_sel <= SCREEN_START;
            hold_cnt   <= '0;
            pending    <= 1'b0;
        end else if (pending) begin
            if (frame_tick) begin
                screen_sel <= screen_of(target);
                state      <= target;
                pending    <= 1'b0;
            end
        end else begin
            case (state)
                START: if (start_rise) begin
                    target  <= GAME;
                    pending <= 1'b1;
                end
                GAME: if (over_rise) begin
                    target  <= GAMEOVER;
                    pending <= 1'b1;
                end
                GAMEOVER: if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        target   <= START;
                        pending  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: state <= START;
            endcase
        end
    end
`else
    localparam int FC_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [FC_W-1:0] STEP_LAST = FC_W'(FADE_STEP_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt;
    logic            step;

    // A fade step fires on the last frame tick of each step period.
    assign step = frame_tick && (frame_cnt == STEP_LAST);

    // Screen FSM: fade out, swap the screen at level 0, fade back in to target.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= START;
            target     <= START;
            screen_sel <= SCREEN_START;
            fade       <= FADE_MAX;
            frame_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                START: if (start_rise) begin
                    target    <= GAME;
                    state     <= FADE_OUT;
                    frame_cnt <= '0;
                end
                GAME: if (over_rise) begin
                    target    <= GAMEOVER;
                    state     <= FADE_OUT;
                    frame_cnt <= '0;
                end
                GAMEOVER: if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt  <= '0;
                        target    <= START;
                        state     <= FADE_OUT;
                        frame_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                FADE_OUT: if (frame_tick) begin
                    if (step) begin
                        frame_cnt <= '0;
                        if (fade == 4'd0) begin
                            screen_sel <= screen_of(target);
                            state      <= FADE_IN;
                        end else begin
                            fade <= fade - 4'd1;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end
                FADE_IN: if (frame_tick) begin
                    if (step) begin
                        frame_cnt <= '0;
                        if (fade == FADE_MAX) begin
                            state <= target;
                        end else begin
                            fade <= fade + 4'd1;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end
                default: state <= START;
            endcase
        end
    end
`endif

    fade_scale u_fade_r (.c(pal_red),   .fade(fade), .c_out(red_s));
    fade_scale u_fade_g (.c(pal_green), .fade(fade), .c_out(green_s));
    fade_scale u_fade_b (.c(pal_blue),  .fade(fade), .c_out(blue_s));

    // Output colour register; black outside active video.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else if (blank) begin
            red   <= red_s;
            green <= green_s;
            blue  <= blue_s;
        end else begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level display-flow controller for the full-screen image path (start, game, game-over screens).
- Sequences screens with a frame-timed FSM and applies a per-frame fade (brightness scale) to the palette RGB.
- Produces the stretched ROM address and the ROM/palette select, and registers the final VGA colour.
- Sits between the VGA timing generator and the per-screen ROM/palette instances. The game logic supplies start and game-over events.

Parameters:
- H_RES, 640, active horizontal pixels.
- V_RES, 480, active vertical lines.
- IMG_W, 320, stored image width.
- IMG_H, 240, stored image height.
- FADE_STEP_FRAMES, 4, frames per fade level step (must be ≥1).
- HOLD_FRAMES, 120, frames the game-over screen is held before fading out.

Ports:
- vga_clk  input  1  pixel clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- DrawX  input  10  current pixel x.
- DrawY  input  10  current pixel y.
- blank  input  1  1 = active video (colour allowed).
- start_key  input  1  start request, level; edge-detected internally.
- game_over  input  1  game-over event, level; edge-detected internally.
- pal_red, pal_green, pal_blue  input  4 each  palette output of the selected screen.
- rom_address  output  17  (DrawX*IMG_W)/H_RES + ((DrawY*IMG_H)/V_RES)*IMG_W, combinational.
- screen_sel  output  2  0 = start, 1 = game, 2 = game-over; 3 is never driven.
- in_game  output  1  state == GAME.
- fading  output  1  state is FADE_OUT or FADE_IN.
- red, green, blue  output  4 each  registered, faded colour.

Behaviour:
- Reset values: state = START, screen_sel = 0, target = START, fade = 15, frame_cnt = 0, hold_cnt = 0, red/green/blue = 0, edge registers = 0.
- Reset asserted mid-fade or mid-hold returns to these values immediately.
- frame_tick: one-cycle pulse, registered, when DrawX == 0 && DrawY == 0 and that position differs from the previous cycle. Exactly one tick per frame.
- start_key and game_over are edge-detected (rise) against their previous-cycle values.
- States:
  - START: show screen 0 at fade 15. A start_key rise sets target = GAME and moves to FADE_OUT.
  - FADE_OUT: each frame_tick increments frame_cnt. When frame_cnt reaches FADE_STEP_FRAMES-1, clear it and decrement fade.
    - When fade is 0 and the step fires: screen_sel takes target's screen and the FSM moves to FADE_IN.
  - FADE_IN: same step timing, but fade increments. When fade is 15 and the step fires, the FSM moves to target.
  - GAME: a game_over rise sets target = GAMEOVER and moves to FADE_OUT.
  - GAMEOVER: hold_cnt counts frame_ticks. At HOLD_FRAMES-1: clear hold_cnt, set target = START, move to FADE_OUT.
- Events and ticks:
  - start_key and game_over events outside their accepting state are dropped and not queued.
  - An event on the same cycle as frame_tick is accepted; frame_cnt restarts at 0.
- Fade duration: a fade-out step sequence takes 16*FADE_STEP_FRAMES frame_ticks from entry.
  - Fade levels 15 → 0 inclusive, with a step at level 0 for the screen swap.
  - Fade-in is symmetric.
- Colour: c_out = (c*fade + 7)/15 per channel.
  - 8-bit product; integer divide by constant.
  - fade 15 gives c exactly; fade 0 gives 0.
- Output register: red/green/blue update on posedge. The value is c_out when blank = 1, else 0.
- Latency: ROM is read on negedge (owned by the ROM instance), and the colour is registered on the following posedge. Net one-cycle pixel pipeline, unchanged from the existing screen path.
- Width rules:
  - rom_address intermediate products are at least 19 bits wide.
  - rom_address max = IMG_W*IMG_H-1 = 76799.

Optional Feature:
- Macro: SCREEN_INSTANT_SWITCH_EN.
- Defined: FADE_OUT and FADE_IN are bypassed.
  - An accepted event sets screen_sel and the target state on the next frame_tick.
  - fade stays 15 and fading stays 0.
- Undefined: full fade behaviour as above.

Decomposition:
- Shared package screen_pkg:
  - enum screen_state_t {START, FADE_OUT, FADE_IN, GAME, GAMEOVER}.
  - Constants SCREEN_START = 2'd0, SCREEN_GAME = 2'd1, SCREEN_OVER = 2'd2.
  - FADE_MAX = 4'd15.
- One sub-module: fade_scale, a combinational per-channel multiply/round/divide, instantiated three times.

Test Plan:
- Reset: assert reset mid-frame → red/green/blue = 0, screen_sel = 0, fade = 15; after release with blank = 1 and pal = 4'hF, red = 4'hF one cycle later.
- Start flow (FADE_STEP_FRAMES = 4):
  - start_key rise in START → fading = 1.
  - Colour at pal = 15 reaches 8 after 7 steps (28 frames) and 0 after 60 frames.
  - screen_sel = 1 at 64 frames; in_game = 1 after a further 64 frames.
- Game over: game_over rise in GAME → fade out, screen_sel = 2 after 64 frames, fade in.
  - Hold 120 frames, then fade out, and screen_sel = 0 after a further 64 frames.
- Ignored events:
  - start_key pulses during fade and GAME do not change state.
  - game_over in START leaves state = START.
- Addressing and blanking:
  - DrawX = 639, DrawY = 479 → rom_address = 76799.
  - DrawX = 2, DrawY = 3 → 321.
  - blank = 0 forces colour 0 regardless of fade.
- SCREEN_INSTANT_SWITCH_EN build: start_key rise → screen_sel = 1 and in_game = 1 on the next frame_tick; fading never asserts.
